th_peak_det: RTL and testbench

Parametrised successor to the single-channel threshold filter in the heart-rate front end. It turns a raw sample stream into peak events, in three stages:
- a moving-average smoother over 2^AVG_LOG2 samples;
- a threshold comparator with programmable threshold, hysteresis and polarity;
- a refractory period that suppresses double-triggering.

On each detected beat it reports the extreme value and the sample interval since the previous beat. It sits between the input sampler and the top-level output mux.

---
 rtl/th_peak_det_pkg.sv | 17 +
 rtl/th_peak_det_mavg.sv | 43 ++++
 rtl/th_peak_det.sv | 148 ++++++++++++++
 tb/tb_th_peak_det.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/th_peak_det_pkg.sv
// Shared FSM state encodings and a saturating increment for the peak detector.
package th_peak_det_pkg;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_EXCUR = 2'd1,
    ST_REFR  = 2'd2
  } th_state_e;

  // Increment v, holding at 2^w - 1 (w must be below 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/th_peak_det_mavg.sv
// Moving-average smoother: window of 2^AVG_LOG2 samples plus a running sum.
// AVG_LOG2 = 0 degenerates to a registered pass-through.
module th_mavg #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] fop,
  output logic              fop_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0] win [DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_new;

  // New sum adds the incoming sample and drops the oldest one in the window.
  assign sum_new = sum + SUM_W'(in) - SUM_W'(win[DEPTH-1]);

  // Window shift, running sum and the registered average output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      sum       <= '0;
      fop       <= '0;
      fop_valid <= 1'b0;
    end else begin
      fop_valid <= in_valid;
      if (in_valid) begin
        win[0] <= in;
        for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
        sum <= sum_new;
        fop <= DATA_W'(sum_new >> AVG_LOG2);
      end
    end
  end

endmodule

// File: rtl/th_peak_det.sv
// Peak detector: moving average -> threshold/hysteresis comparator ->
// refractory FSM, reporting the excursion extreme and the beat interval.
// Strobe semantics: in_valid marks one sample per cycle it is high, with no
// back-pressure; fop_valid marks the filtered tick one cycle later and peak
// marks the beat one cycle after that. The state output exposes the FSM.
module th_peak_det
  import th_peak_det_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 4,
  parameter int REFRACT  = 16,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic              thr_load,
  input  logic [DATA_W-1:0] thr_in,
  input  logic              higher,
  output logic [DATA_W-1:0] fop,
  output logic              fop_valid,
  output logic              peak,
  output logic [DATA_W-1:0] peak_val,
  output logic [CNT_W-1:0]  interval,
  output logic              interval_valid,
  output th_state_e         state
);

  localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RW-1:0] REFR_LAST = RW'((REFRACT > 0) ? REFRACT - 1 : 0);

  logic [DATA_W-1:0] thr;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] t;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_new;
  logic              higher_q;
  logic              flip;
  logic              enter;
  logic              leave;
  logic              peak_tick;
  th_state_e         state_next;
  logic [RW-1:0]     refr_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              seen_peak;

  th_mavg #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_mavg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .fop      (fop),
    .fop_valid(fop_valid)
  );

  // Low-going detection is folded onto the high-going compare by inverting.
  assign x       = higher ? fop : ~fop;
  assign t       = higher ? thr : ~thr;
  assign enter   = x > t;
  // One extra bit so x + HYST cannot wrap past the top of the range.
  assign leave   = ({1'b0, x} + (DATA_W + 1)'(HYST)) < {1'b0, t};
  assign max_new = (x > max_q) ? x : max_q;
  assign flip    = higher != higher_q;
  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), CNT_W));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_next;
  end

  // Next state; a polarity change mid-excursion aborts without a beat.
  always_comb begin
    state_next = state;
    peak_tick  = 1'b0;
    if (state == ST_EXCUR && flip) begin
      state_next = ST_ARMED;
    end else if (fop_valid) begin
      case (state)
        ST_ARMED: if (enter) state_next = ST_EXCUR;
        ST_EXCUR: begin
          if (leave) begin
            peak_tick  = 1'b1;
            state_next = (REFRACT == 0) ? ST_ARMED : ST_REFR;
          end
        end
        ST_REFR:  if (refr_cnt == REFR_LAST) state_next = ST_ARMED;
        default:  state_next = ST_ARMED;
      endcase
    end
  end

  // Threshold register and the previous polarity for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr      <= {1'b1, {(DATA_W-1){1'b0}}};
      higher_q <= 1'b0;
    end else begin
      higher_q <= higher;
      if (thr_load) thr <= thr_in;
    end
  end

  // Extreme tracking (in compare domain) and refractory tick count.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q    <= '0;
      refr_cnt <= '0;
    end else begin
      if (state == ST_ARMED && state_next == ST_EXCUR) max_q <= x;
      else if (state == ST_EXCUR && fop_valid)         max_q <= max_new;
      if (peak_tick)                          refr_cnt <= '0;
      else if (state == ST_REFR && fop_valid) refr_cnt <= refr_cnt + RW'(1);
    end
  end

  // Beat outputs and the saturating interval counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak           <= 1'b0;
      peak_val       <= '0;
      interval       <= '0;
      interval_valid <= 1'b0;
      seen_peak      <= 1'b0;
      cnt            <= '0;
    end else begin
      peak           <= 1'b0;
      interval_valid <= 1'b0;
      if (peak_tick) begin
        peak           <= 1'b1;
        peak_val       <= higher ? max_new : ~max_new;
        interval       <= cnt_inc;
        interval_valid <= seen_peak;
        seen_peak      <= 1'b1;
        cnt            <= '0;
      end else if (fop_valid) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_th_peak_det.sv
// Directed bench for th_peak_det: reset, filter ramp, beat/interval,
// hysteresis, refractory, low-polarity and abort scenarios.
module tb_th_peak_det;
  import th_peak_det_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_s = 8'd0;
  logic        thr_load = 1'b0;
  logic [7:0]  thr_in = 8'd0;
  logic        higher = 1'b1;

  logic [7:0]  fop, peak_val;
  logic        fop_valid, peak, interval_valid;
  logic [11:0] interval;
  th_state_e   state;

  logic [7:0]  a_fop, a_peak_val;
  logic        a_fop_valid, a_peak, a_interval_valid;
  logic [11:0] a_interval;
  th_state_e   a_state;

  int          checks = 0;
  int          failures = 0;
  int          pk_total = 0;
  int          base;
  logic [7:0]  last_pv = 8'd0;
  logic [11:0] last_int = 12'd0;
  logic        last_iv = 1'b0;

  // Clock.
  always #5 clk = ~clk;

  th_peak_det #(
    .DATA_W(8), .AVG_LOG2(0), .HYST(4), .REFRACT(16), .CNT_W(12)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_s),
    .thr_load(thr_load), .thr_in(thr_in), .higher(higher),
    .fop(fop), .fop_valid(fop_valid), .peak(peak), .peak_val(peak_val),
    .interval(interval), .interval_valid(interval_valid), .state(state)
  );

  th_peak_det #(
    .DATA_W(8), .AVG_LOG2(2), .HYST(4), .REFRACT(16), .CNT_W(12)
  ) dut_avg (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_s),
    .thr_load(thr_load), .thr_in(thr_in), .higher(higher),
    .fop(a_fop), .fop_valid(a_fop_valid), .peak(a_peak), .peak_val(a_peak_val),
    .interval(a_interval), .interval_valid(a_interval_valid), .state(a_state)
  );

  // Beat monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (peak) begin
      pk_total = pk_total + 1;
      last_pv  = peak_val;
      last_int = interval;
      last_iv  = interval_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_s     = v;
    cycle();
  endtask

  task automatic send_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic flush();
    in_valid = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic pulse();
    send(8'd60); send(8'd70); send(8'd80); send(8'd90);
    send(8'd80); send(8'd70); send(8'd60); send(8'd50); send(8'd45);
  endtask

  initial begin
    // Reset with strobes active: everything must come out zero.
    reset = 1'b1; in_valid = 1'b1; in_s = 8'd200;
    repeat (3) cycle();
    reset = 1'b0; in_valid = 1'b0;
    check("rst_fop", 32'(fop), 32'd0);
    check("rst_fop_valid", 32'(fop_valid), 32'd0);
    check("rst_peak", 32'(peak), 32'd0);
    check("rst_peak_val", 32'(peak_val), 32'd0);
    check("rst_interval", 32'(interval), 32'd0);
    check("rst_interval_valid", 32'(interval_valid), 32'd0);
    check("rst_state", 32'(state), 32'(ST_ARMED));

    // Default threshold 128: 129 starts an excursion.
    send(8'd129);
    in_valid = 1'b0;
    check("thr_def_fop", 32'(fop), 32'd129);
    check("thr_def_fop_valid", 32'(fop_valid), 32'd1);
    cycle();
    check("thr_def_state", 32'(state), 32'(ST_EXCUR));
    base = pk_total;
    reset = 1'b1; cycle(); reset = 1'b0;
    flush();
    check("rst_mid_state", 32'(state), 32'(ST_ARMED));
    check("rst_mid_nopeak", 32'(pk_total - base), 32'd0);

    // Filter ramp with AVG_LOG2=2.
    send(8'd100); check("avg_1", 32'(a_fop), 32'd25);
    check("avg_1_valid", 32'(a_fop_valid), 32'd1);
    send(8'd100); check("avg_2", 32'(a_fop), 32'd50);
    send(8'd100); check("avg_3", 32'(a_fop), 32'd75);
    send(8'd100); check("avg_4", 32'(a_fop), 32'd100);
    in_valid = 1'b0;
    cycle();
    check("avg_hold", 32'(a_fop), 32'd100);
    check("avg_valid_low", 32'(a_fop_valid), 32'd0);

    // Beat detection, thr=50, higher=1.
    reset = 1'b1; cycle(); reset = 1'b0;
    thr_in = 8'd50; thr_load = 1'b1; cycle(); thr_load = 1'b0;
    base = pk_total;
    pulse();
    send_n(8'd20, 31);
    flush();
    check("beat1_count", 32'(pk_total - base), 32'd1);
    check("beat1_val", 32'(last_pv), 32'd90);
    check("beat1_iv", 32'(last_iv), 32'd0);
    base = pk_total;
    pulse();
    flush();
    check("beat2_count", 32'(pk_total - base), 32'd1);
    check("beat2_val", 32'(last_pv), 32'd90);
    check("beat2_iv", 32'(last_iv), 32'd1);
    check("beat2_int", 32'(last_int), 32'd40);

    // Hysteresis: hovering around the threshold gives no beat.
    send_n(8'd20, 20);
    base = pk_total;
    send(8'd60);
    for (int i = 0; i < 20; i++) send(8'(47 + (i % 6)));
    flush();
    check("hyst_hover", 32'(pk_total - base), 32'd0);
    send(8'd45);
    flush();
    check("hyst_exit_count", 32'(pk_total - base), 32'd1);
    check("hyst_val", 32'(last_pv), 32'd60);
    check("hyst_int", 32'(last_int), 32'd42);

    // Refractory: excursion 10 ticks after a beat ignored, 20 ticks after taken.
    base = pk_total;
    send_n(8'd20, 9);
    send_n(8'd80, 3);
    send_n(8'd20, 7);
    flush();
    check("refr_ignored", 32'(pk_total - base), 32'd0);
    send_n(8'd80, 3);
    send(8'd20);
    flush();
    check("refr_after_count", 32'(pk_total - base), 32'd1);
    check("refr_after_val", 32'(last_pv), 32'd80);
    check("refr_after_int", 32'(last_int), 32'd23);

    // Low polarity: dip to 10 reported as 10.
    higher = 1'b0;
    send_n(8'd60, 20);
    base = pk_total;
    send(8'd40); send(8'd20); send(8'd10); send(8'd30); send(8'd60);
    flush();
    check("low_count", 32'(pk_total - base), 32'd1);
    check("low_val", 32'(last_pv), 32'd10);
    check("low_int", 32'(last_int), 32'd25);

    // Polarity flip mid-dip aborts.
    send_n(8'd60, 20);
    base = pk_total;
    send(8'd40); send(8'd20);
    flush();
    check("flip_pre_state", 32'(state), 32'(ST_EXCUR));
    higher = 1'b1; cycle();
    check("flip_state", 32'(state), 32'(ST_ARMED));
    higher = 1'b0; cycle();
    send_n(8'd60, 3);
    flush();
    check("flip_nopeak", 32'(pk_total - base), 32'd0);
    check("flip_end_state", 32'(state), 32'(ST_ARMED));

    // Reset mid-dip emits nothing.
    send(8'd40); send(8'd20);
    flush();
    check("rdip_pre_state", 32'(state), 32'(ST_EXCUR));
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rdip_state", 32'(state), 32'(ST_ARMED));
    check("rdip_peak_val", 32'(peak_val), 32'd0);
    flush();
    check("rdip_nopeak", 32'(pk_total - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
